// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the program-counter / fetch sequencer.
package pc_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Next-PC select for the PC register.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program-counter register: async reset to RESET_PC, then load / increment / hold.
module pc_fetch_unit_pc_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           sel_i,
    input  logic [ADDR_W-1:0] load_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Select the next PC; the increment wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_LOAD: pc_d = load_i;
            PC_INC:  pc_d = pc_q + PC_STEP;
            default: pc_d = pc_q;
        endcase
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus instruction-fetch sequencer: issues word reads over
// req/ready and presents the fetched word and its PC to decode over valid/ready.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic               redirect,
    input  logic               halt_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic [ADDR_W-1:0]  plus_q, plus_d;
    pc_sel_e            pc_sel;
    logic [ADDR_W-1:0]  pc;

    pc_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .sel_i  (pc_sel),
        .load_i (addr_in),
        .pc_o   (pc)
    );

    // Next-state logic: halt beats redirect, redirect beats normal progress.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        plus_d  = plus_q;
        pc_sel  = PC_HOLD;

        if (state_q == HALT) begin
            // Frozen until reset.
            req_d = 1'b0;
        end else if (halt_in) begin
            // Any presented instruction is dropped; the PC is not touched.
            state_d = HALT;
            req_d   = 1'b0;
        end else if (redirect) begin
            // Same-cycle read data is discarded; the next request uses addr_in.
            pc_sel  = PC_LOAD;
            state_d = FETCH;
            req_d   = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    // Data is only accepted against an outstanding request.
                    if (req_q && imem_ready) begin
                        instr_d = imem_rdata;
                        ipc_d   = pc;
                        plus_d  = pc + PC_STEP;
                        state_d = VALID;
                        req_d   = 1'b0;
                    end else begin
                        req_d = 1'b1;
                    end
                end
                VALID: begin
                    req_d = 1'b0;
                    if (dec_ready) begin
                        pc_sel  = PC_INC;
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, request flag and the decode-side instruction latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            plus_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            plus_q  <= plus_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = (state_q == VALID);
    assign halted      = (state_q == HALT);
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign pc_plus     = plus_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed per-cycle vector table, async reset
// sequences, then randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] addr_in;
    logic        redirect;
    logic        halt_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .redirect    (redirect),
        .halt_in     (halt_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .pc_plus     (pc_plus),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected visible outputs.
    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iout;
        logic [31:0] ipc;
        logic [31:0] plus;
        logic        hlt;
    } exp_t;

    typedef struct {
        logic        redir;
        logic [31:0] addr;
        logic        halt;
        logic        rdy;
        logic [31:0] rdata;
        logic        dec;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic redir, input logic [31:0] addr, input logic halt,
                       input logic rdy, input logic [31:0] rdata, input logic dec,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_out, input logic [31:0] e_pc,
                       input logic [31:0] e_plus, input logic e_halt);
        vec_t v;
        v.redir = redir; v.addr = addr; v.halt = halt;
        v.rdy = rdy; v.rdata = rdata; v.dec = dec;
        v.e.req = e_req; v.e.addr = e_addr; v.e.valid = e_valid;
        v.e.iout = e_out; v.e.ipc = e_pc; v.e.plus = e_plus; v.e.hlt = e_halt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, expv);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag, input int idx, input exp_t e);
        chk({tag, ".imem_req"},    idx, {31'd0, imem_req},    {31'd0, e.req});
        chk({tag, ".imem_addr"},   idx, imem_addr,            e.addr);
        chk({tag, ".instr_valid"}, idx, {31'd0, instr_valid}, {31'd0, e.valid});
        chk({tag, ".instr_out"},   idx, instr_out,            e.iout);
        chk({tag, ".instr_pc"},    idx, instr_pc,             e.ipc);
        chk({tag, ".pc_plus"},     idx, pc_plus,              e.plus);
        chk({tag, ".halted"},      idx, {31'd0, halted},      {31'd0, e.hlt});
    endtask

    task automatic drive(input logic redir, input logic [31:0] addr, input logic halt,
                         input logic rdy, input logic [31:0] rdata, input logic dec);
        redirect = redir; addr_in = addr; halt_in = halt;
        imem_ready = rdy; imem_rdata = rdata; dec_ready = dec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from any clock edge and check the outputs clear at once.
    task automatic async_reset(input string tag, input int idx);
        exp_t z;
        z = '{req: 1'b0, addr: 32'h0, valid: 1'b0, iout: 32'h0, ipc: 32'h0, plus: 32'h0, hlt: 1'b0};
        rst = 1'b1;
        #1;
        chk_all(tag, idx, z);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Transaction-level model: what the fetch unit holds and what it is asking for.
    typedef struct {
        logic [31:0] pc;          // address of the instruction being fetched next
        bit          holding;     // an instruction is on offer to decode
        bit          asking;      // a memory read is outstanding
        bit          stopped;
        logic [31:0] word;
        logic [31:0] word_pc;
        logic [31:0] link;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.pc = 32'h0; m.holding = 0; m.asking = 0; m.stopped = 0;
        m.word = 32'h0; m.word_pc = 32'h0; m.link = 32'h0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic redir, input logic [31:0] addr,
                                          input logic halt, input logic rdy, input logic [31:0] rdata,
                                          input logic dec);
        model_t n = m;
        if (m.stopped) begin
            return n;
        end
        if (halt) begin
            n.stopped = 1; n.holding = 0; n.asking = 0;
        end else if (redir) begin
            n.pc = addr; n.holding = 0; n.asking = 1;
        end else if (m.holding) begin
            if (dec) begin
                n.pc = m.pc + 32'd1; n.holding = 0; n.asking = 1;
            end
        end else if (m.asking && rdy) begin
            n.word = rdata; n.word_pc = m.pc; n.link = m.pc + 32'd1;
            n.holding = 1; n.asking = 0;
        end else begin
            n.asking = 1;
        end
        return n;
    endfunction

    function automatic exp_t model_out(input model_t m);
        exp_t e;
        e.req = m.asking; e.addr = m.pc; e.valid = m.holding;
        e.iout = m.word; e.ipc = m.word_pc; e.plus = m.link; e.hlt = m.stopped;
        return e;
    endfunction

    initial begin
        exp_t   e;
        model_t m;
        int     halt_cycles;

        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0, 0);

        // Sequential fetch with zero-wait memory and decode.
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0,         32'h0, 32'h0, 0);
        add(0, 0, 0, 1, 32'h1000_0000, 1, 0, 32'h0, 1, 32'h1000_0000, 32'h0, 32'h1, 0);
        add(0, 0, 0, 1, 32'h0,         1, 1, 32'h1, 0, 32'h1000_0000, 32'h0, 32'h1, 0);
        add(0, 0, 0, 1, 32'h1000_0001, 1, 0, 32'h1, 1, 32'h1000_0001, 32'h1, 32'h2, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h2, 0, 32'h1000_0001, 32'h1, 32'h2, 0);
        add(0, 0, 0, 1, 32'h1000_0002, 1, 0, 32'h2, 1, 32'h1000_0002, 32'h2, 32'h3, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h3, 0, 32'h1000_0002, 32'h2, 32'h3, 0);
        add(0, 0, 0, 1, 32'h1000_0003, 1, 0, 32'h3, 1, 32'h1000_0003, 32'h3, 32'h4, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h4, 0, 32'h1000_0003, 32'h3, 32'h4, 0);
        add(0, 0, 0, 1, 32'h1000_0004, 1, 0, 32'h4, 1, 32'h1000_0004, 32'h4, 32'h5, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h5, 0, 32'h1000_0004, 32'h4, 32'h5, 0);
        // Memory stalls three cycles at pc = 5.
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 32'h0,     1, 1, 32'h5, 0, 32'h1000_0004, 32'h4, 32'h5, 0);
        add(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h5, 1, 32'hDEAD_BEEF, 32'h5, 32'h6, 0);
        // Decode stalls four cycles: everything holds, no new request.
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 1, 32'h1234_5678, 0, 0, 32'h5, 1, 32'hDEAD_BEEF, 32'h5, 32'h6, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h6, 0, 32'hDEAD_BEEF, 32'h5, 32'h6, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h6, 0, 32'hDEAD_BEEF, 32'h5, 32'h6, 0);
        // Redirect while waiting in FETCH, with a same-cycle ready that must be dropped.
        add(1, 32'h40, 0, 1, 32'h0BAD_0BAD, 0, 1, 32'h40, 0, 32'hDEAD_BEEF, 32'h5, 32'h6, 0);
        add(0, 0, 0, 1, 32'h0000_4040, 0, 0, 32'h40, 1, 32'h0000_4040, 32'h40, 32'h41, 0);
        // Redirect during a handshake: consumed, but PC goes to the target (all ones).
        add(1, 32'hFFFF_FFFF, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0000_4040, 32'h40, 32'h41, 0);
        add(0, 0, 0, 1, 32'h0000_7777, 0, 0, 32'hFFFF_FFFF, 1, 32'h0000_7777, 32'hFFFF_FFFF, 32'h0, 0);
        add(0, 0, 0, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0000_7777, 32'hFFFF_FFFF, 32'h0, 0);
        // Back-to-back redirects: the last one wins.
        add(1, 32'h100, 0, 0, 32'h0,   0, 1, 32'h100, 0, 32'h0000_7777, 32'hFFFF_FFFF, 32'h0, 0);
        add(1, 32'h200, 0, 1, 32'h00BA_DBAD, 0, 1, 32'h200, 0, 32'h0000_7777, 32'hFFFF_FFFF, 32'h0, 0);
        add(0, 0, 0, 1, 32'h0000_2222, 0, 0, 32'h200, 1, 32'h0000_2222, 32'h200, 32'h201, 0);
        // Halt in VALID with a simultaneous redirect and handshake: halt wins, pc frozen.
        add(1, 32'h999, 1, 0, 32'h0,   1, 0, 32'h200, 0, 32'h0000_2222, 32'h200, 32'h201, 1);
        add(1, 32'h555, 0, 1, 32'h1,   1, 0, 32'h200, 0, 32'h0000_2222, 32'h200, 32'h201, 1);
        add(0, 0, 0, 0, 32'h0,         0, 0, 32'h200, 0, 32'h0000_2222, 32'h200, 32'h201, 1);

        // Reset state while rst is held.
        #12;
        e = '{req: 1'b0, addr: 32'h0, valid: 1'b0, iout: 32'h0, ipc: 32'h0, plus: 32'h0, hlt: 1'b0};
        chk_all("reset", 0, e);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].redir, tbl[i].addr, tbl[i].halt, tbl[i].rdy, tbl[i].rdata, tbl[i].dec);
            step();
            chk_all("vec", i, tbl[i].e);
            $display("vec %0d: req=%0b addr=%h valid=%0b out=%h pc=%h plus=%h halted=%0b",
                     i, imem_req, imem_addr, instr_valid, instr_out, instr_pc, pc_plus, halted);
        end

        // Only reset leaves HALT; afterwards fetching restarts at RESET_PC.
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        async_reset("halt_rst", 0);
        step();
        e = '{req: 1'b1, addr: 32'h0, valid: 1'b0, iout: 32'h0, ipc: 32'h0, plus: 32'h0, hlt: 1'b0};
        chk_all("restart", 0, e);
        drive(0, 32'h0, 0, 1, 32'h0000_0055, 0);
        step();
        e = '{req: 1'b0, addr: 32'h0, valid: 1'b1, iout: 32'h55, ipc: 32'h0, plus: 32'h1, hlt: 1'b0};
        chk_all("restart", 1, e);
        drive(0, 32'h0, 0, 0, 32'h0, 1);
        step();
        e = '{req: 1'b1, addr: 32'h1, valid: 1'b0, iout: 32'h55, ipc: 32'h0, plus: 32'h1, hlt: 1'b0};
        chk_all("restart", 2, e);
        // Reset mid-FETCH with a request outstanding clears everything without a clock edge.
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        async_reset("fetch_rst", 0);

        // Randomized traffic against the model.
        m = model_reset();
        halt_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        r_redir, r_halt, r_rdy, r_dec;
            logic [31:0] r_addr, r_rdata;
            if ((m.stopped && halt_cycles >= 4) || $urandom_range(0, 399) == 0) begin
                drive(0, 32'h0, 0, 0, 32'h0, 0);
                async_reset("rand_rst", c);
                m = model_reset();
                halt_cycles = 0;
            end
            r_redir = ($urandom_range(0, 7) == 0);
            r_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            r_halt  = ($urandom_range(0, 149) == 0);
            r_rdy   = (m.asking || m.holding || m.stopped) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_rdata = $urandom;
            r_dec   = 1'($urandom_range(0, 1));
            drive(r_redir, r_addr, r_halt, r_rdy, r_rdata, r_dec);
            m = model_step(m, r_redir, r_addr, r_halt, r_rdy, r_rdata, r_dec);
            step();
            chk_all("rand", c, model_out(m));
            if (m.stopped) halt_cycles++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
